lcd_text_buffer: RTL and testbench



---
 rtl/lcd_pkg.sv | 21 ++
 rtl/lcd_text_ram.sv | 24 ++
 rtl/lcd_text_buffer.sv | 132 +++++++++++++
 tb/tb_lcd_text_buffer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, control codes and FSM state types for the LCD text buffer.
package lcd_pkg;
  localparam int LINE_WIDTH = 16;
  localparam int LINES      = 4;
  localparam int MEM_DEPTH  = LINE_WIDTH * LINES;
  localparam int ADDR_W     = $clog2(MEM_DEPTH);

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CTRL_CR    = 8'h0D;
  localparam logic [7:0] CTRL_LF    = 8'h0A;
  localparam logic [7:0] CTRL_BS    = 8'h08;
  localparam logic [7:0] CTRL_FF    = 8'h0C;

  typedef enum logic {W_IDLE, W_CLEAR} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ARM, R_PRINT} r_state_t;

  // Everything from space upward except DEL lands in the image.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CHAR_SPACE) && (b != 8'h7F);
  endfunction
endpackage

// File: rtl/lcd_text_ram.sv
// 64x8 simple dual-port character RAM: one write port, one registered read port.
module lcd_text_ram
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; a same-address write returns old data.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/lcd_text_buffer.sv
// Host byte decoder, cursor, clear sequencer and refresh trigger for the HD44780 driver.
// Handshake: a host byte transfers on a rising clk where wr_valid & wr_ready are both 1.
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int TRG_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              lcd_busy,
  output logic              lcd_trg,
  output logic [ADDR_W-1:0] cursor,
  output logic              dirty,
  output w_state_t          w_state_dbg,
  output r_state_t          r_state_dbg
);
  localparam int CNT_W = $clog2(TRG_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WIDTH - 1);

  w_state_t          w_state;
  r_state_t          r_state;
  logic [ADDR_W-1:0] clr_addr;
  logic [CNT_W-1:0]  arm_cnt;
  logic              accept, is_print, clear_done, trg_fire, arm_timeout, dirty_set;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  assign wr_ready    = (w_state == W_IDLE);
  assign accept      = wr_valid & wr_ready;
  assign is_print    = is_printable(wr_data);
  assign clear_done  = (w_state == W_CLEAR) && (clr_addr == ADDR_W'(MEM_DEPTH - 1));
  assign trg_fire    = (r_state == R_IDLE) && dirty && !lcd_busy && (w_state == W_IDLE);
  assign arm_timeout = (r_state == R_ARM) && !lcd_busy && (arm_cnt == CNT_W'(TRG_TIMEOUT - 1));
  assign dirty_set   = (accept & is_print) | clear_done | arm_timeout;
  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cursor;
    mem_wdata = wr_data;
    if (w_state == W_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = CHAR_SPACE;
    end else if (accept && is_print) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_CLEAR;
      clr_addr <= '0;
      cursor   <= '0;
    end else begin
      case (w_state)
        W_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clear_done) w_state <= W_IDLE;
        end
        W_IDLE: begin
          if (accept) begin
            if (is_print) begin
              cursor <= cursor + 1'b1;
            end else begin
              case (wr_data)
                CTRL_CR: cursor <= cursor & LINE_MASK;
                CTRL_LF: cursor <= (cursor & LINE_MASK) + ADDR_W'(LINE_WIDTH);
                CTRL_BS: cursor <= cursor - 1'b1;
                CTRL_FF: begin
                  cursor   <= '0;
                  clr_addr <= '0;
                  w_state  <= W_CLEAR;
                end
                default: ;
              endcase
            end
          end
        end
        default: w_state <= W_CLEAR;
      endcase
    end
  end

  // A new change in the same cycle as the trigger keeps dirty set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      lcd_trg <= 1'b0;
      arm_cnt <= '0;
      dirty   <= 1'b0;
    end else begin
      lcd_trg <= 1'b0;
      dirty   <= dirty_set | (dirty & ~trg_fire);
      case (r_state)
        R_IDLE: begin
          if (trg_fire) begin
            lcd_trg <= 1'b1;
            arm_cnt <= '0;
            r_state <= R_ARM;
          end
        end
        R_ARM: begin
          if (lcd_busy)         r_state <= R_PRINT;
          else if (arm_timeout) r_state <= R_IDLE;
          else                  arm_cnt <= arm_cnt + 1'b1;
        end
        R_PRINT: begin
          if (!lcd_busy) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  lcd_text_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_lcd_text_buffer.sv
// Self-checking bench for lcd_text_buffer: reference image/cursor model, read scoreboard,
// behavioural HD44780 busy responder and a trigger protocol monitor.
module tb_lcd_text_buffer;
  import lcd_pkg::*;

  localparam int PRINT_LEN = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              lcd_busy;
  logic              lcd_trg;
  logic [ADDR_W-1:0] cursor;
  logic              dirty;
  w_state_t          w_state_dbg;
  r_state_t          r_state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]        exp_q[$];
  logic [7:0]        model_mem [MEM_DEPTH];
  logic [ADDR_W-1:0] model_cursor;

  logic model_en   = 1'b0;
  logic model_busy = 1'b0;
  logic man_busy   = 1'b0;
  logic pend       = 1'b0;
  int   busy_cnt   = 0;
  int   trg_cnt    = 0;
  int   viol       = 0;
  logic prev_trg   = 1'b0;

  assign lcd_busy = model_en ? model_busy : man_busy;

  always #5 clk = ~clk;

  lcd_text_buffer #(.TRG_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .lcd_busy    (lcd_busy),
    .lcd_trg     (lcd_trg),
    .cursor      (cursor),
    .dirty       (dirty),
    .w_state_dbg (w_state_dbg),
    .r_state_dbg (r_state_dbg)
  );

  // Driver model: busy rises the cycle after a trigger and lasts PRINT_LEN cycles.
  initial forever begin
    @(posedge clk); #1;
    if (!model_en) begin
      model_busy = 1'b0; pend = 1'b0; busy_cnt = 0;
    end else if (pend) begin
      model_busy = 1'b1; busy_cnt = PRINT_LEN; pend = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) model_busy = 1'b0;
    end
    if (model_en && lcd_trg) pend = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (lcd_trg && (prev_trg || lcd_busy)) viol++;
    if (lcd_trg) trg_cnt++;
    prev_trg = lcd_trg;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    foreach (model_mem[i]) model_mem[i] = CHAR_SPACE;
    model_cursor = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (!wr_ready && waited < 200) begin
      tick(1);
      waited++;
    end
    n_tests++;
    if (!wr_ready) begin
      n_fail++;
      $display("FAIL send_ready: wr_ready=%0b required 1 for byte %0h", wr_ready, b);
    end else begin
      wr_valid = 1'b1;
      wr_data  = b;
      tick(1);
      wr_valid = 1'b0;
      if (b >= 8'h20 && b != 8'h7F) begin
        model_mem[model_cursor] = b;
        model_cursor = model_cursor + 1'b1;
      end else if (b == 8'h0D) begin
        model_cursor = {model_cursor[5:4], 4'b0000};
      end else if (b == 8'h0A) begin
        model_cursor = {model_cursor[5:4] + 2'd1, 4'b0000};
      end else if (b == 8'h08) begin
        model_cursor = model_cursor - 1'b1;
      end else if (b == 8'h0C) begin
        model_clear();
      end
    end
  endtask

  task automatic check_cell(input logic [ADDR_W-1:0] a);
    logic [7:0] e;
    rd_addr = a;
    exp_q.push_back(model_mem[a]);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (rd_data !== e) begin
      n_fail++;
      $display("FAIL cell[%0d]: rd_data=%0h required %0h", a, rd_data, e);
    end
  endtask

  task automatic check_all_cells();
    for (int a = 0; a < MEM_DEPTH; a++) check_cell(ADDR_W'(a));
    #1;
  endtask

  // Call right after the edge that started the clear; wr_ready must first be seen in cycle 65.
  task automatic measure_clear(input string name);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!wr_ready && cnt < 200);
    n_tests++;
    if (cnt != 65) begin
      n_fail++;
      $display("FAIL %s_ready_cycle: wr_ready rose in cycle %0d required 65", name, cnt);
    end
    n_tests++;
    if (dirty !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_dirty: dirty=%0b required 1", name, dirty);
    end
  endtask

  task automatic check_cursor(input string name, input logic [ADDR_W-1:0] e);
    @(negedge clk);
    n_tests++;
    if (cursor !== e || cursor !== model_cursor) begin
      n_fail++;
      $display("FAIL %s: cursor=%0d required %0d (model %0d)", name, cursor, e, model_cursor);
    end
    #1;
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
    man_busy = 1'b0; model_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (wr_ready !== 1'b0 || lcd_trg !== 1'b0 || dirty !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: wr_ready=%0b lcd_trg=%0b dirty=%0b required 0 0 0",
               wr_ready, lcd_trg, dirty);
    end
    n_tests++;
    if (cursor !== '0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: cursor=%0d rd_data=%0h required 0 00", cursor, rd_data);
    end
    n_tests++;
    if (w_state_dbg !== W_CLEAR || r_state_dbg !== R_IDLE) begin
      n_fail++;
      $display("FAIL reset_states: w=%0d r=%0d required %0d %0d",
               w_state_dbg, r_state_dbg, W_CLEAR, R_IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    base = trg_cnt;
    measure_clear("reset");
    n_tests++;
    if (lcd_trg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_early_trg: lcd_trg=%0b in cycle 65 required 0", lcd_trg);
    end
    tick(100);
    n_tests++;
    if (trg_cnt - base != 1) begin
      n_fail++;
      $display("FAIL reset_trg_count: pulses=%0d required 1", trg_cnt - base);
    end
    check_all_cells();
  endtask

  task automatic test_hi();
    int base;
    model_en = 1'b0; man_busy = 1'b1;
    tick(1);
    base = trg_cnt;
    send_byte("H");
    send_byte("I");
    check_cursor("hi_cursor", 6'd2);
    check_cell(6'd0);
    check_cell(6'd1);
    tick(10);
    n_tests++;
    if (trg_cnt - base != 0) begin
      n_fail++;
      $display("FAIL hi_trg_while_busy: pulses=%0d required 0", trg_cnt - base);
    end
    model_en = 1'b1;
    tick(60);
    n_tests++;
    if (trg_cnt - base != 1) begin
      n_fail++;
      $display("FAIL hi_trg_count: pulses=%0d required 1", trg_cnt - base);
    end
  endtask

  task automatic test_lf_cr();
    send_byte("a"); send_byte("b"); send_byte("c");
    check_cursor("lf_pre", 6'd5);
    send_byte(CTRL_LF);
    check_cursor("lf_after", 6'd16);
    send_byte("x"); send_byte("y");
    check_cursor("cr_pre", 6'd18);
    send_byte(CTRL_CR);
    check_cursor("cr_after", 6'd16);
    send_byte("A");
    check_cursor("cr_char", 6'd17);
    check_cell(6'd16);
    check_cell(6'd17);
    for (int i = 0; i < 3; i++) send_byte(CTRL_LF);
    check_cursor("lf_wrap", 6'd0);
    send_byte(8'h1B);
    check_cursor("other_code", 6'd0);
    check_cell(6'd0);
  endtask

  task automatic test_wrap();
    send_byte(CTRL_BS);
    check_cursor("bs_wrap0", 6'd63);
    send_byte("Z");
    check_cursor("wrap_end", 6'd0);
    check_cell(6'd63);
    send_byte(CTRL_BS);
    check_cursor("bs_back", 6'd63);
    send_byte(8'hC5);
    send_byte(8'h7F);
    check_cursor("hi_byte", 6'd0);
    check_cell(6'd63);
    check_cell(6'd0);
  endtask

  task automatic wait_trg(input string name);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!lcd_trg && w < 30);
    n_tests++;
    if (!lcd_trg) begin
      n_fail++;
      $display("FAIL %s: lcd_trg=%0b after %0d cycles required 1", name, lcd_trg, w);
    end
  endtask

  task automatic test_busy_hold();
    int base;
    model_en = 1'b1;
    tick(60);
    model_en = 1'b0; man_busy = 1'b0;
    tick(1);
    base = trg_cnt;
    send_byte("Q");
    wait_trg("hold_first_trg");
    @(posedge clk); #1;
    man_busy = 1'b1;
    tick(3);
    send_byte("R");
    tick(30);
    n_tests++;
    if (trg_cnt - base != 1) begin
      n_fail++;
      $display("FAIL hold_no_retrg: pulses=%0d required 1", trg_cnt - base);
    end
    n_tests++;
    if (dirty !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_dirty: dirty=%0b required 1", dirty);
    end
    model_en = 1'b1;
    tick(60);
    n_tests++;
    if (trg_cnt - base != 2) begin
      n_fail++;
      $display("FAIL hold_after_fall: pulses=%0d required 2", trg_cnt - base);
    end
  endtask

  task automatic test_timeout();
    int gap = 0;
    model_en = 1'b0; man_busy = 1'b0;
    tick(2);
    send_byte("T");
    wait_trg("timeout_first_trg");
    do begin
      @(negedge clk);
      gap++;
    end while (!lcd_trg && gap < 30);
    n_tests++;
    if (gap != 5) begin
      n_fail++;
      $display("FAIL timeout_gap: retrigger after %0d cycles required 5", gap);
    end
    #1;
    model_en = 1'b1;
    tick(60);
  endtask

  task automatic test_ff();
    send_byte("X"); send_byte("Y");
    send_byte(CTRL_FF);
    measure_clear("ff");
    check_cursor("ff_cursor", 6'd0);
    check_all_cells();
    send_byte("K"); send_byte("L");
    send_byte(CTRL_FF);
    tick(29);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_clear();
    measure_clear("ff_rst");
    check_cursor("ff_rst_cursor", 6'd0);
    check_all_cells();
    model_en = 1'b1;
    tick(60);
  endtask

  initial begin
    test_reset();
    test_hi();
    test_lf_cr();
    test_wrap();
    test_busy_hold();
    test_timeout();
    test_ff();
    n_tests++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL trg_protocol: violations=%0d required 0", viol);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
